data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the cache-to-data-memory line interface. Serves 256-bit line reads and writes requested by the data cache.
- Accepts one request at a time: enable, write flag, address, write line. Models a fixed access latency, then answers with a one-cycle ack and, for reads, the line data.
- Sits between the data cache and the line storage array.

Parameters:
- LINE_W, 256, line width in bits (fixed 32 bytes; offset bits = 5)
- DEPTH_LINES, 512, number of lines stored; power of two; IDX_W = log2(DEPTH_LINES)
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- mem_enable_i  in  1  request valid; sampled only in IDLE
- mem_write_i  in  1  1 = line write, 0 = line read
- mem_addr_i  in  32  byte address; bits [4:0] ignored; line index = addr[5+IDX_W-1:5]
- mem_data_i  in  LINE_W  write line
- mem_ack_o  out  1  one-cycle completion pulse
- mem_data_o  out  LINE_W  read line; valid while mem_ack_o=1 and held afterwards
- busy_o  out  1  high from acceptance until the end of the ACK cycle

Behaviour:
- Reset is asynchronous and active-low: rst_n_i low forces the state machine to IDLE immediately. mem_ack_o=0, mem_data_o=0, busy_o=0, counter=0.
- Line array contents are not reset.
- States:
  - IDLE: if mem_enable_i=1 at an edge, latch write flag, line index and write line; load counter with LATENCY-1; go to WAIT.
  - WAIT: counter decrements each edge. At the edge where counter==0, commit the access and go to ACK.
    - Read: mem_data_o <= array[idx].
    - Write: array[idx] <= latched line; mem_data_o unchanged.
  - ACK: mem_ack_o=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: acceptance edge E0; ack is high in the cycle following edge E_LATENCY. With LATENCY=1, ack follows the very next edge.
- Input changes after acceptance (addr, data, write, enable) are ignored until IDLE is re-entered.
- mem_enable_i during WAIT or ACK is ignored.
- The requester must drop enable by the edge closing the ACK cycle. Enable still high in IDLE is a new request, giving back-to-back service with one IDLE-free gap (ACK→IDLE→accept).
- Address bits above the index wrap modulo DEPTH_LINES, unless the optional feature below is compiled in.
- Reset during WAIT aborts the access: a pending write is not committed and no ack is produced.
- Reset during ACK clears mem_ack_o immediately.
- mem_ack_o and busy_o are registered; no combinational input-to-output paths.

Optional Feature:
- DMEM_RANGE_CHECK_EN
- When defined:
  - Adds output port mem_err_o (1 bit, reset 0).
  - Any request with addr[31:5+IDX_W] != 0 still follows IDLE→WAIT→ACK timing.
  - It does not touch the array.
  - It drives mem_data_o <= 0 for reads.
  - It asserts mem_err_o together with mem_ack_o for the ACK cycle only.
- When undefined: no mem_err_o port; upper bits silently wrap.

Decomposition:
- Shared package dmem_pkg:
  - LINE_W and OFFSET_W=5 constants
  - state typedef (IDLE, WAIT, ACK)
  - line_t typedef (logic [LINE_W-1:0])
- Natural sub-module: dmem_line_array, a single-port synchronous RAM with DEPTH_LINES×LINE_W, write enable, index, and registered read. The controller drives it at the commit edge.

Test Plan:
- Reset then write/read: write 0xA5 repeated at addr 0x0000_0040, then read the same address → each ack comes exactly 10 cycles after acceptance; read returns the 0xA5 pattern.
- Offset ignored: write at 0x0000_0060, read at 0x0000_007C → same line returned.
- Input churn: change addr and data during WAIT; hold enable high through ACK → first access uses the latched values; second request accepted the cycle after ACK returns to IDLE.
- Reset mid-write: assert rst_n_i=0 at counter=3, then read the line → old contents returned; no ack pulse during the reset.
- LATENCY=1 build: request at E0 → mem_ack_o high after E1, low after E2.
- DMEM_RANGE_CHECK_EN with DEPTH_LINES=512: write to 0x0001_0000 → mem_err_o=1 with ack; a later read of line 0 still returns its prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, registered read.
// The read register also provides the clear path used for rejected reads.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = LINE_W,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Responder for cache line reads/writes with a fixed access latency.
// Optional DMEM_RANGE_CHECK_EN adds mem_err_o and rejects out-of-range addresses.
module data_memory_responder
    import dmem_pkg::state_e, dmem_pkg::IDLE, dmem_pkg::WAIT, dmem_pkg::ACK,
           dmem_pkg::OFFSET_W;
#(
    parameter int unsigned LINE_W      = 256,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned LATENCY     = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o,
`ifdef DMEM_RANGE_CHECK_EN
    output logic              mem_err_o,
`endif
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TOP_B = OFFSET_W + IDX_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               oor_q, oor_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               commit;
    logic               req_oor;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr_i[OFFSET_W-1:0], mem_addr_i[31:TOP_B]};

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign req_oor = (mem_addr_i[31:TOP_B] != '0);
`else
    assign req_oor = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            line_q  <= '0;
            oor_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            oor_q   <= oor_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        line_d  = line_q;
        oor_d   = oor_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    wr_d    = mem_write_i;
                    idx_d   = mem_addr_i[TOP_B-1:OFFSET_W];
                    line_d  = mem_data_i;
                    oor_d   = req_oor;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they carry no input path.
        busy_d = (state_d != IDLE);
        ack_d  = (state_d == ACK);
    end

`ifdef DMEM_RANGE_CHECK_EN
    always_comb begin
        err_d = (state_d == ACK) && oor_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err_o = err_q;
`endif

    dmem_line_array #(
        .DEPTH (DEPTH_LINES),
        .WIDTH (LINE_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (commit && wr_q && !oor_q),
        .re_i    (commit && !wr_q && !oor_q),
        .clr_i   (commit && !wr_q && oor_q),
        .idx_i   (idx_q),
        .wdata_i (line_q),
        .rdata_o (mem_data_o)
    );

    assign mem_ack_o = ack_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (default build and LATENCY=1 instance).
module tb_data_memory_responder;
    import dmem_pkg::*;

    localparam int unsigned LAT = 10;

    localparam line_t PA5 = {32{8'hA5}};
    localparam line_t P1  = {8{32'hDEADBEEF}};
    localparam line_t P2  = {4{64'h0123456789ABCDEF}};
    localparam line_t P3  = {16{16'h5A3C}};
    localparam line_t Q1  = {8{32'h13579BDF}};
    localparam line_t PZ  = {32{8'h3C}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, wr;
    logic [31:0] addr;
    line_t       wdata;
    logic        ack, busy;
    line_t       rdata;
    logic        err_s;

    logic        en1, wr1;
    logic [31:0] addr1;
    line_t       wd1;
    logic        ack1, busy1;
    line_t       rd1;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    data_memory_responder #(
        .LINE_W      (LINE_W),
        .DEPTH_LINES (512),
        .LATENCY     (LAT)
    ) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mem_enable_i (en),
        .mem_write_i  (wr),
        .mem_addr_i   (addr),
        .mem_data_i   (wdata),
        .mem_ack_o    (ack),
        .mem_data_o   (rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .mem_err_o    (err_s),
`endif
        .busy_o       (busy)
    );

`ifndef DMEM_RANGE_CHECK_EN
    assign err_s = 1'b0;
`else
    logic err1;
`endif

    data_memory_responder #(
        .LINE_W      (LINE_W),
        .DEPTH_LINES (512),
        .LATENCY     (1)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mem_enable_i (en1),
        .mem_write_i  (wr1),
        .mem_addr_i   (addr1),
        .mem_data_i   (wd1),
        .mem_ack_o    (ack1),
        .mem_data_o   (rd1),
`ifdef DMEM_RANGE_CHECK_EN
        .mem_err_o    (err1),
`endif
        .busy_o       (busy1)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Waits for ack after an acceptance edge; lat counts edges E1..En.
    task automatic wait_ack(output int unsigned lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 40);
    endtask

    task automatic do_access(input string nm, input logic w, input logic [31:0] a,
                             input line_t d, output line_t rd, output logic e);
        int unsigned lat;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        chk({nm, "_busy_accept"}, 256'(busy), 256'(1));
        @(negedge clk);
        en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        wait_ack(lat);
        chk({nm, "_latency"}, 256'(lat), 256'(LAT));
        rd = rdata;
        e  = err_s;
        @(posedge clk); #1;
        chk({nm, "_ack_drop"}, 256'({ack, busy, err_s}), 256'(0));
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        line_t       d;
        line_t       exp_rd;
    } vec_t;

    vec_t tv[9];

    initial begin
        line_t       rd;
        logic        e;
        int unsigned lat;
        logic        ack_seen;

        tv[0] = '{1'b1, 32'h0000_0040, PA5, '0};
        tv[1] = '{1'b0, 32'h0000_0040, '0,  PA5};
        tv[2] = '{1'b1, 32'h0000_0060, P1,  PA5};
        tv[3] = '{1'b0, 32'h0000_007C, '0,  P1};
        tv[4] = '{1'b1, 32'h0000_1FE0, P2,  P1};
        tv[5] = '{1'b0, 32'h0000_1FE0, '0,  P2};
        tv[6] = '{1'b1, 32'h0000_3FE0, P3,  P2};
        tv[7] = '{1'b0, 32'h0000_3FFF, '0,  P3};
        tv[8] = '{1'b0, 32'h0000_0055, '0,  PA5};

        rst_n = 1'b0;
        en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 256'({ack, busy, err_s}), 256'(0));
        chk("reset_data", rdata, '0);
        chk("reset_ctrl1", 256'({ack1, busy1}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_access($sformatf("vec%0d", i), tv[i].w, tv[i].a, tv[i].d, rd, e);
            chk($sformatf("vec%0d_data", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 256'(e), 256'(0));
        end

        // Input churn: latched values used, enable held through ACK.
        do_access("pre_churn", 1'b0, 32'h0000_0060, '0, rd, e);
        chk("pre_churn_data", rd, P1);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0080; wdata = Q1;
        @(posedge clk); #1;
        chk("churn_busy", 256'(busy), 256'(1));
        @(negedge clk);
        wr = 1'b0; addr = 32'h0000_0040; wdata = PZ;
        wait_ack(lat);
        chk("churn_lat1", 256'(lat), 256'(LAT));
        chk("churn_write_holds_data", rdata, P1);
        @(posedge clk); #1;
        chk("churn_idle_gap", 256'({ack, busy}), 256'(0));
        @(posedge clk); #1;
        chk("churn_second_accept", 256'(busy), 256'(1));
        @(negedge clk);
        en = 1'b0;
        wait_ack(lat);
        chk("churn_lat2", 256'(lat), 256'(LAT));
        chk("churn_read_data", rdata, PA5);
        @(posedge clk); #1;
        chk("churn_ack_drop", 256'(ack), 256'(0));
        do_access("churn_verify", 1'b0, 32'h0000_0080, '0, rd, e);
        chk("churn_verify_data", rd, Q1);

        // Reset while the counter reads 3 aborts the write.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0040; wdata = PZ;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; wr = 1'b0; wdata = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_busy_before", 256'({ack, busy}), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", 256'({ack, busy}), 256'(0));
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) ack_seen = 1'b1;
        end
        chk("rst_no_ack", 256'(ack_seen), 256'(0));
        chk("rst_data_clear", rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_access("rst_readback", 1'b0, 32'h0000_0040, '0, rd, e);
        chk("rst_readback_data", rd, PA5);

        // LATENCY=1 instance.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            en1 = 1'b1; wr1 = (k == 0); addr1 = 32'h0000_0020; wd1 = (k == 0) ? Q1 : PZ;
            @(posedge clk); #1;
            chk($sformatf("lat1_e0_%0d", k), 256'({ack1, busy1}), 256'(1));
            @(negedge clk);
            en1 = 1'b0; wr1 = 1'b0; wd1 = '0;
            @(posedge clk); #1;
            chk($sformatf("lat1_e1_%0d", k), 256'({ack1, busy1}), 256'(3));
            if (k == 1) chk("lat1_read_data", rd1, Q1);
            @(posedge clk); #1;
            chk($sformatf("lat1_e2_%0d", k), 256'({ack1, busy1}), 256'(0));
        end

`ifdef DMEM_RANGE_CHECK_EN
        do_access("rng_w0", 1'b1, 32'h0000_0000, P2, rd, e);
        chk("rng_w0_err", 256'(e), 256'(0));
        do_access("rng_oor_w", 1'b1, 32'h0001_0000, PZ, rd, e);
        chk("rng_oor_w_err", 256'(e), 256'(1));
        do_access("rng_r0", 1'b0, 32'h0000_0000, '0, rd, e);
        chk("rng_r0_data", rd, P2);
        chk("rng_r0_err", 256'(e), 256'(0));
        do_access("rng_oor_r", 1'b0, 32'h0001_0000, '0, rd, e);
        chk("rng_oor_r_data", rd, '0);
        chk("rng_oor_r_err", 256'(e), 256'(1));
`else
        // Upper address bits wrap onto line 2.
        do_access("wrap_r", 1'b0, 32'h0000_4040, '0, rd, e);
        chk("wrap_r_data", rd, PA5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
